// File: rtl/weight_fifo_arr_control_if.sv
// weight_fifo_arr_control_if: signal bundle between the weight-load controller and its neighbours
//   master : the controller/memory/FIFO side, which drives the start request, its parameters and the memory read data
//   slave  : the weight_fifo_arr_control block, which drives memory reads, FIFO push/pop, the array shift/latch controls and the status outputs
interface weight_fifo_arr_control_if #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int DATA_WIDTH   = WIDTH_HEIGHT * 8,
    parameter int ADDR_WIDTH   = 8
);
    logic                            weight_fifo_arr_en;
    logic [$clog2(WIDTH_HEIGHT)-1:0] num_row_weight_mat;
    logic [ADDR_WIDTH-1:0]           base_addr;
    logic                            weight_mem_rd_en;
    logic [ADDR_WIDTH-1:0]           weight_mem_addr;
    logic [DATA_WIDTH-1:0]           weight_mem_rd_data;
    logic                            fifo_wr_en;
    logic [DATA_WIDTH-1:0]           fifo_wr_data;
    logic                            fifo_rd_en;
    logic                            weight_shift_en;
    logic                            weight_zero;
    logic                            weight_latch_en;
    logic                            busy;
    logic                            weight_fifo_arr_done;

    modport master (
        output weight_fifo_arr_en, num_row_weight_mat, base_addr, weight_mem_rd_data,
        input  weight_mem_rd_en, weight_mem_addr, fifo_wr_en, fifo_wr_data, fifo_rd_en,
               weight_shift_en, weight_zero, weight_latch_en, busy, weight_fifo_arr_done
    );

    modport slave (
        input  weight_fifo_arr_en, num_row_weight_mat, base_addr, weight_mem_rd_data,
        output weight_mem_rd_en, weight_mem_addr, fifo_wr_en, fifo_wr_data, fifo_rd_en,
               weight_shift_en, weight_zero, weight_latch_en, busy, weight_fifo_arr_done
    );
endinterface

// File: rtl/weight_fifo_arr_control.sv
// weight_fifo_arr_control: fetches N weight rows from memory into the weight FIFO, drains them into the systolic array shift chain, latches them and pulses done
//   clk, reset : clock and synchronous active-high reset
//   bus        : weight_fifo_arr_control_if.slave (start/params in; memory read, FIFO push/pop, shift/zero/latch, busy, done out)
//   WEIGHT_ZERO_PAD_EN : when defined, every load shifts WIDTH_HEIGHT rows, zero-padding past the N fetched rows
module weight_fifo_arr_control #(
    parameter int WIDTH_HEIGHT = 16,
    parameter int DATA_WIDTH   = WIDTH_HEIGHT * 8,
    parameter int ADDR_WIDTH   = 8
) (
    input logic                      clk,
    input logic                      reset,
    weight_fifo_arr_control_if.slave bus
);
    localparam int CW = $clog2(WIDTH_HEIGHT);

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, LOAD, SETTLE, LATCH, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic [CW-1:0] n_q;
    logic [CW-1:0] load_last;

`ifdef WEIGHT_ZERO_PAD_EN
    assign load_last = CW'(WIDTH_HEIGHT - 1);
`else
    assign load_last = n_q;
    assign bus.weight_zero = 1'b0;
`endif

    assign bus.fifo_wr_data = bus.weight_mem_rd_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state                    <= IDLE;
            cnt                      <= '0;
            n_q                      <= '0;
            bus.weight_mem_rd_en     <= 1'b0;
            bus.weight_mem_addr      <= '0;
            bus.fifo_wr_en           <= 1'b0;
            bus.fifo_rd_en           <= 1'b0;
            bus.weight_shift_en      <= 1'b0;
            bus.weight_latch_en      <= 1'b0;
            bus.busy                 <= 1'b0;
            bus.weight_fifo_arr_done <= 1'b0;
`ifdef WEIGHT_ZERO_PAD_EN
            bus.weight_zero          <= 1'b0;
`endif
        end else begin
            // The FIFO push trails the memory read by its one-cycle latency; the
            // array shift trails the FIFO pop by the FIFO's one-cycle read latency.
            bus.fifo_wr_en           <= bus.weight_mem_rd_en;
            bus.weight_shift_en      <= state == LOAD;
            bus.weight_latch_en      <= 1'b0;
            bus.weight_fifo_arr_done <= 1'b0;
`ifdef WEIGHT_ZERO_PAD_EN
            bus.weight_zero          <= state == LOAD && cnt > n_q;
`endif
            case (state)
                IDLE: if (bus.weight_fifo_arr_en) begin
                    state                <= FETCH;
                    cnt                  <= '0;
                    n_q                  <= bus.num_row_weight_mat;
                    bus.weight_mem_rd_en <= 1'b1;
                    bus.weight_mem_addr  <= bus.base_addr;
                    bus.busy             <= 1'b1;
                end
                FETCH: if (cnt == n_q) begin
                    state                <= DRAIN;
                    bus.weight_mem_rd_en <= 1'b0;
                end else begin
                    cnt                  <= cnt + 1'b1;
                    bus.weight_mem_addr  <= bus.weight_mem_addr + 1'b1;
                end
                DRAIN: begin
                    state          <= LOAD;
                    cnt            <= '0;
                    bus.fifo_rd_en <= 1'b1;
                end
                // Pops stop after the N stored rows even when padded shifts continue.
                LOAD: if (cnt == load_last) begin
                    state          <= SETTLE;
                    bus.fifo_rd_en <= 1'b0;
                end else begin
                    cnt            <= cnt + 1'b1;
                    bus.fifo_rd_en <= cnt < n_q;
                end
                SETTLE: begin
                    state               <= LATCH;
                    bus.weight_latch_en <= 1'b1;
                end
                LATCH: begin
                    state                    <= DONE;
                    bus.weight_fifo_arr_done <= 1'b1;
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_weight_fifo_arr_control.sv
// tb_weight_fifo_arr_control: randomized and directed checks of weight_fifo_arr_control against a cycle-schedule model
module tb_weight_fifo_arr_control;
    localparam int WH   = 16;
    localparam int AW   = 8;
    localparam int DW   = WH * 8;
    localparam int NW   = $clog2(WH);
    localparam int MAXC = 8192;
`ifdef WEIGHT_ZERO_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    weight_fifo_arr_control_if #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW)) bus ();
    weight_fifo_arr_control #(.WIDTH_HEIGHT(WH), .ADDR_WIDTH(AW)) dut (.clk(clk), .reset(reset), .bus(bus));

    logic [DW-1:0] mem [256];
    bit            e_rd [MAXC], e_wr [MAXC], e_frd [MAXC], e_sh [MAXC], e_z [MAXC];
    bit            e_lat [MAXC], e_done [MAXC], e_busy [MAXC], d_seen [MAXC];
    logic [AW-1:0] e_addr [MAXC];
    logic [DW-1:0] e_wdata [MAXC];
    int  cyc = 0, free_at = 0, tests = 0, fails = 0;
    bit  chk = 1'b0;

    task automatic check(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Schedule every output of an accepted operation directly from its start cycle t.
    task automatic model(input int c, input bit r, input bit en, input int nr, input logic [AW-1:0] ba);
        int n, l;
        if (r) begin
            for (int i = c + 1; i < MAXC && i < c + 64; i++) begin
                e_rd[i] = 0; e_wr[i] = 0; e_frd[i] = 0; e_sh[i] = 0; e_z[i] = 0;
                e_lat[i] = 0; e_done[i] = 0; e_busy[i] = 0;
            end
            free_at = c + 1;
        end else if (en && c >= free_at) begin
            n = nr + 1;
            l = PAD ? WH : n;
            for (int k = 0; k < n; k++) begin
                e_rd[c + 1 + k]      = 1;
                e_addr[c + 1 + k]    = ba + AW'(k);
                e_wr[c + 2 + k]      = 1;
                e_wdata[c + 2 + k]   = mem[ba + AW'(k)];
                e_frd[c + n + 2 + k] = 1;
            end
            for (int j = 0; j < l; j++) begin
                e_sh[c + n + 3 + j] = 1;
                e_z[c + n + 3 + j]  = j >= n;
            end
            e_lat[c + n + l + 3]  = 1;
            e_done[c + n + l + 4] = 1;
            for (int i = c + 1; i <= c + n + l + 4; i++) e_busy[i] = 1;
            free_at = c + n + l + 5;
        end
    endtask

    task automatic step(input bit r, input bit en, input int nr, input logic [AW-1:0] ba);
        bit            prd;
        logic [AW-1:0] pa;
        reset                  = r;
        bus.weight_fifo_arr_en = en;
        bus.num_row_weight_mat = NW'(nr);
        bus.base_addr          = ba;
        prd = bus.weight_mem_rd_en === 1'b1;
        pa  = bus.weight_mem_addr;
        model(cyc, r, en, nr, ba);
        @(posedge clk);
        #1;
        bus.weight_mem_rd_data = prd ? mem[pa] : {$urandom, $urandom, $urandom, $urandom};
        cyc++;
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step(0, 0, 0, 0);
    endtask

    always @(negedge clk) if (chk) begin
        check("rd_en", bus.weight_mem_rd_en, e_rd[cyc]);
        if (e_rd[cyc]) check("addr", bus.weight_mem_addr, e_addr[cyc]);
        check("wr_en", bus.fifo_wr_en, e_wr[cyc]);
        if (e_wr[cyc]) check("wr_data", bus.fifo_wr_data, e_wdata[cyc]);
        check("fifo_rd_en", bus.fifo_rd_en, e_frd[cyc]);
        check("shift_en", bus.weight_shift_en, e_sh[cyc]);
        check("zero", bus.weight_zero, e_z[cyc]);
        check("latch", bus.weight_latch_en, e_lat[cyc]);
        check("done", bus.weight_fifo_arr_done, e_done[cyc]);
        check("busy", bus.busy, e_busy[cyc]);
        d_seen[cyc] = bus.weight_fifo_arr_done === 1'b1;
    end

    initial begin
        int t, cnt;
        for (int i = 0; i < 256; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
        bus.weight_mem_rd_data = '0;
        // 1: reset with en held high
        step(1, 1, 5, 8'h40);
        chk = 1'b1;
        step(1, 1, 5, 8'h40);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.weight_fifo_arr_done, 1'b0);
        idle(3);
        // 2: base 0x10, N=4
        t = cyc;
        step(0, 1, 3, 8'h10);
        idle(30);
        check("t2_model_addr", e_addr[t + 4], 8'h13);
        check("t2_model_frd", e_frd[t + 6], 1'b1);
`ifdef WEIGHT_ZERO_PAD_EN
        check("t6_done", d_seen[t + 24], 1'b1);
        check("t6_zero_on", e_z[t + 11], 1'b1);
        check("t6_zero_off", e_z[t + 10], 1'b0);
        check("t6_shift_last", e_sh[t + 22], 1'b1);
        check("t6_latch", e_lat[t + 23], 1'b1);
`else
        check("t2_done", d_seen[t + 12], 1'b1);
        check("t2_shift_last", e_sh[t + 10], 1'b1);
        check("t2_latch", e_lat[t + 11], 1'b1);
`endif
        // 3: address wrap
        t = cyc;
        step(0, 1, 3, 8'hFE);
        idle(30);
        check("t3_wrap_addr", e_addr[t + 3], 8'h00);
`ifdef WEIGHT_ZERO_PAD_EN
        check("t3_done", d_seen[t + 24], 1'b1);
`else
        check("t3_done", d_seen[t + 12], 1'b1);
`endif
        // 4: en held for 21 cycles with N=1
        t = cyc;
        for (int i = 0; i <= 20; i++) step(0, 1, 0, 8'h33);
        idle(25);
`ifdef WEIGHT_ZERO_PAD_EN
        check("t4_done1", d_seen[t + 21], 1'b1);
`else
        check("t4_done1", d_seen[t + 6], 1'b1);
        check("t4_gap", d_seen[t + 7], 1'b0);
        check("t4_done2", d_seen[t + 13], 1'b1);
`endif
        // 5: reset mid-operation, then a full-size load
        t = cyc;
        step(0, 1, 15, 8'h80);
        idle(4);
        step(1, 0, 0, 0);
        idle(2);
        step(0, 1, 15, 8'h90);
        idle(45);
        cnt = 0;
        for (int i = t + 1; i < t + 44; i++) cnt += int'(d_seen[i]);
        check("t5_no_early_done", cnt, 0);
        check("t5_done", d_seen[t + 44], 1'b1);
        // random traffic, with occasional reset
        for (int i = 0; i < 2500; i++)
            step($urandom_range(0, 79) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, WH - 1), AW'($urandom));
        idle(50);
        chk = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
